// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with one registered prefix level per stage
// and a valid/ready stream handshake; every stage stalls together under backpressure.
module ks_adder_pipe #(
  parameter int unsigned WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned NSTG   = LEVELS + 2;

  logic                          adv;
  logic [NSTG-1:0]               vld_q;
  logic [WIDTH-1:0]              bb;
  logic                          c0_d;
  logic [LEVELS:0][WIDTH-1:0]    g_d, p_d;
  logic [LEVELS:0][WIDTH-1:0]    g_q, p_q, pb_q;
  logic [LEVELS:0]               c0_q;
  logic [WIDTH-1:0]              carry;
  logic [WIDTH-1:0]              sum_d, sum_q;
  logic                          cout_d, cout_q, ovf_d, ovf_q;

  assign out_valid = vld_q[NSTG-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  assign bb     = sub ? ~b : b;
  assign c0_d   = sub | cin;
  assign g_d[0] = a & bb;
  assign p_d[0] = a ^ bb;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_black
        assign g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-D]);
        assign p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-D];
      end else if (i + 1 == D) begin : g_gray
        assign g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & c0_q[k-1]);
        assign p_d[k][i] = p_q[k-1][i];
      end else begin : g_buf
        assign g_d[k][i] = g_q[k-1][i];
        assign p_d[k][i] = p_q[k-1][i];
      end
    end
  end

  // When WIDTH+1 exceeds 2^LEVELS the top group never meets carry-in inside the tree;
  // its group propagate spans down to bit 0, so folding c0 here completes every carry.
  assign carry  = g_q[LEVELS] | (p_q[LEVELS] & {WIDTH{c0_q[LEVELS]}});
  assign sum_d  = pb_q[LEVELS] ^ {carry[WIDTH-2:0], c0_q[LEVELS]};
  assign cout_d = carry[WIDTH-1];
  assign ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[NSTG-2:0], in_valid & in_ready};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      g_q    <= g_d;
      p_q    <= p_d;
      pb_q   <= {pb_q[LEVELS-1:0], p_d[0]};
      c0_q   <= {c0_q[LEVELS-1:0], c0_d};
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign sum  = out_valid ? sum_q : '0;
  assign cout = out_valid & cout_q;
  assign ovf  = out_valid & ovf_q;

endmodule
